pipelined_bypass_adder: RTL
===========================

# pipelined_bypass_adder

Parametrised, pipelined carry-skip adder/subtractor with valid/ready flow control on both sides. Operands are split into STAGES register-separated slices; each slice is built from BLOCK-bit carry-skip groups, and the carry ripples between slices through pipeline registers. It sustains one operation per cycle. It is the datapath adder for the arithmetic units that previously instantiated the combinational 32-bit bypass adder, and adds subtract mode, signed-overflow reporting and backpressure.

## Interface
- WIDTH, 32, operand/result width; must be a multiple of BLOCK*STAGES
- BLOCK, 4, carry-skip group size in bits
- STAGES, 2, pipeline depth; slice width = WIDTH/STAGES; STAGES ≥ 1
- Reset: one clock; reset is asynchronous and active-low (clk, rst_n).
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand beat present
- in_ready  out  1  block accepts beat this cycle
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- cin  in  1  carry-in; used only when sub=0
- sub  in  1  0: A+B+cin; 1: A+~B+1 (A−B)
- out_valid  out  1  result present
- out_ready  in  1  downstream accepts result
- sum  out  WIDTH  result, modulo 2^WIDTH
- cout  out  1  carry out of MSB (sub mode: 1 = no borrow)
- ovf  out  1  two's-complement overflow

## Operation
- Effective operand: B' = sub ? ~b : b. Effective carry: c0 = sub ? 1 : cin.
- Stage k (0..STAGES−1) adds bits [k*S +: S] (S = WIDTH/STAGES) using the carry registered by stage k−1. Stage 0 uses c0.
- Within a stage:
  - Each BLOCK-bit group computes propagate P = &(A^B').
  - Group carry-out = P ? group carry-in : rippled carry.
- Pipeline registers carry:
  - Completed low sum slices.
  - Unprocessed high slices of A and B'.
  - Inter-slice carry.
  - A[MSB] and B'[MSB], for overflow.
- Last stage produces:
  - sum
  - cout = carry out of bit WIDTH−1
  - ovf = (A[MSB] == B'[MSB]) && (sum[MSB] != A[MSB])
- Each stage k holds a valid bit v[k]. Stage k advances when v[k] && (k == last ? out_ready : (!v[k+1] || advance[k+1])).
- Stage 0 loads when in_valid && in_ready.
- in_ready = !v[0] || advance[0]. This is combinational and does not depend on in_valid.
- out_valid = v[STAGES−1]. sum, cout and ovf are registered outputs of the last stage.
- While out_valid && !out_ready: sum, cout and ovf hold stable. Upstream stages fill bubbles, then in_ready drops.
- No beat is lost, duplicated or reordered.

## Timing
- Reset (asynchronous, any time, including mid-stream):
  - All v[k] = 0, so out_valid = 0.
  - sum = 0, cout = 0, ovf = 0, all internal data registers = 0.
  - in_ready = 1 in the first cycle after rst_n deasserts.
  - In-flight beats are discarded.
- Latency: a beat accepted at edge t has out_valid = 1 with its result after edge t+STAGES−1, i.e. visible STAGES cycles after acceptance.
- Throughput: one beat per cycle while out_ready = 1.
- Simultaneous accept and drain on a full pipe is legal and keeps throughput.
- in_ready = 0 exactly when all stages are valid and out_ready = 0.
- With in_valid = 0, a, b, cin and sub are don't-care and are never captured.

## Test plan
- WIDTH=32, STAGES=2, add mode:
  - 0x00000001+0x00000001, cin=0 -> sum 0x00000002, cout 0, ovf 0, 2 cycles after accept.
  - 0xFFFFFFFF+0x00000001 -> sum 0x00000000, cout 1, ovf 0.
  - 0x0000FFFF+0x00000001 -> 0x00010000; carry crosses the stage boundary.
- Signed overflow:
  - 0x7FFFFFFF+0x00000001 -> 0x80000000, ovf 1, cout 0.
  - 0x80000000+0xFFFFFFFF -> 0x7FFFFFFF, ovf 1, cout 1.
- Subtract:
  - sub=1, 5−7 -> 0xFFFFFFFE, cout 0, ovf 0.
  - sub=1, 7−5 -> 0x00000002, cout 1.
  - sub=1, 0x80000000−1 -> 0x7FFFFFFF, ovf 1.
  - cin is ignored in all subtract cases.
- Stream of 8 back-to-back beats with out_ready held 0 for 3 cycles mid-stream:
  - in_ready drops after the pipe fills.
  - Outputs stay stable while stalled.
  - All 8 results arrive in order, none lost or duplicated.
- Reset mid-stream with 2 beats in flight -> out_valid 0 and sum 0 immediately; in_ready 1 after release; no stale results emitted.
- Repeat the add and subtract vectors at STAGES=1, STAGES=4, and WIDTH=16/BLOCK=2 -> results identical, latency equals STAGES.

Source files
------------

// File: rtl/pipelined_bypass_adder.sv
// Pipelined carry-skip adder/subtractor with valid/ready flow control.
// Operands are cut into STAGES slices of WIDTH/STAGES bits; each slice is
// added by BLOCK-bit carry-skip groups and the slice carry moves to the next
// stage through a pipeline register. One beat per cycle when unstalled.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   in_valid/in_ready input handshake (in_ready is combinational)
//   a, b, cin, sub    operands; sub=1 computes a-b and ignores cin
//   out_valid/out_ready output handshake
//   sum, cout, ovf    registered result, carry out of MSB, signed overflow
module pipelined_bypass_adder #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned BLOCK  = 4,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned S    = WIDTH / STAGES;
  localparam int unsigned NGRP = S / BLOCK;
  localparam int unsigned LAST = STAGES - 1;

  // One slice: groups ripple internally; a fully-propagating group passes
  // its carry-in straight through (the skip path).
  function automatic logic [S:0] csk_slice(input logic [S-1:0] x,
                                           input logic [S-1:0] y,
                                           input logic         ci);
    logic [S-1:0]   s;
    logic [BLOCK:0] grp;
    logic           gc;
    logic           p;
    s   = '0;
    grp = '0;
    gc  = ci;
    p   = 1'b0;
    for (int unsigned g = 0; g < NGRP; g++) begin
      grp = {1'b0, x[g*BLOCK +: BLOCK]} + {1'b0, y[g*BLOCK +: BLOCK]}
          + {{BLOCK{1'b0}}, gc};
      p   = &(x[g*BLOCK +: BLOCK] ^ y[g*BLOCK +: BLOCK]);
      s[g*BLOCK +: BLOCK] = grp[BLOCK-1:0];
      gc  = p ? gc : grp[BLOCK];
    end
    return {gc, s};
  endfunction

  logic [STAGES-1:0] v;
  logic [STAGES-1:0] adv;
  logic [WIDTH-1:0]  b_eff;
  logic              c0;
  logic              hole;

  assign b_eff = sub ? ~b : b;
  assign c0    = sub ? 1'b1 : cin;

  // A stage moves on when it is valid and some stage below it (or the
  // consumer) can take data; flattened so no bit depends on another bit.
  always_comb begin
    adv  = '0;
    hole = 1'b0;
    for (int unsigned k = 0; k < STAGES; k++) begin
      hole = out_ready;
      for (int unsigned j = k + 1; j < STAGES; j++) begin
        hole = hole | ~v[j];
      end
      adv[k] = v[k] & hole;
    end
  end

  assign in_ready = ~v[0] | adv[0];

  for (genvar k = 0; k < STAGES; k++) begin : g_st
    logic [WIDTH-1:0] a_src;
    logic [WIDTH-1:0] b_src;
    logic [WIDTH-1:0] s_src;
    logic             c_src;
    logic             load;
    logic [S:0]       res;
    logic [WIDTH-1:0] s_nxt;
    logic [WIDTH-1:0] s_q;
    logic             c_q;
    logic             v_q;
    logic             unused_src;

    if (k == 0) begin : g_first
      assign a_src = a;
      assign b_src = b_eff;
      assign s_src = '0;
      assign c_src = c0;
      assign load  = in_valid & in_ready;
    end else begin : g_next
      assign a_src = g_st[k-1].g_fwd.a_q;
      assign b_src = g_st[k-1].g_fwd.b_q;
      assign s_src = g_st[k-1].s_q;
      assign c_src = g_st[k-1].c_q;
      assign load  = adv[k-1];
    end

    // Low operand slices were already consumed upstream.
    assign unused_src = ^{a_src, b_src};

    assign res = csk_slice(a_src[k*S +: S], b_src[k*S +: S], c_src);

    // Merge this stage's slice into the partial sum.
    always_comb begin
      s_nxt = s_src;
      s_nxt[k*S +: S] = res[S-1:0];
    end

    // Stage valid, partial sum and carry; loads only when the slot frees.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q <= 1'b0;
        s_q <= '0;
        c_q <= 1'b0;
      end else if (load) begin
        v_q <= 1'b1;
        s_q <= s_nxt;
        c_q <= res[S];
      end else if (adv[k]) begin
        v_q <= 1'b0;
      end
    end

    assign v[k] = v_q;

    if (k != LAST) begin : g_fwd
      logic [WIDTH-1:0] a_q;
      logic [WIDTH-1:0] b_q;

      // Operands travel with the beat for later slices and the MSB check.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else if (load) begin
          a_q <= a_src;
          b_q <= b_src;
        end
      end
    end else begin : g_ovf
      logic ovf_nxt;
      logic ovf_q;

      assign ovf_nxt = (a_src[WIDTH-1] == b_src[WIDTH-1]) &&
                       (s_nxt[WIDTH-1] != a_src[WIDTH-1]);

      // Signed overflow resolved with the final slice.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ovf_q <= 1'b0;
        end else if (load) begin
          ovf_q <= ovf_nxt;
        end
      end
    end
  end

  assign out_valid = v[LAST];
  assign sum       = g_st[LAST].s_q;
  assign cout      = g_st[LAST].c_q;
  assign ovf       = g_st[LAST].g_ovf.ovf_q;

endmodule
